// File: rtl/stepper_ramp_driver_pkg.sv
// stepper_pkg: shared definitions for stepper_ramp_driver.
//   - direction codes from the joystick decoder (00/11 both mean stop)
//   - ramp state enum
//   - coil pattern tables, entry [0] is phase 0
package stepper_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_e;

  // Full-step: 1100, 0110, 0011, 1001
  localparam logic [3:0][3:0] FULL_PAT = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

  // Half-step: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001
  localparam logic [7:0][3:0] HALF_PAT = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                          4'b0110, 4'b0100, 4'b1100, 4'b1000};

endpackage

// File: rtl/stepper_ramp_driver_if.sv
// stepper_ramp_driver_if: command/coil bundle for one stepper axis.
//   direction  : 2-bit command (01 fwd, 10 rev, 00/11 stop)
//   en         : axis enable, 0 de-energizes the coils
//   signal_out : 4-bit coil pattern to the Pmod STEP header
//   moving     : ramp state is not IDLE
//   step_tick  : one-cycle pulse after every step edge
// master = command source / observer, slave = the driver.
interface stepper_ramp_driver_if;
  logic [1:0] direction;
  logic       en;
  logic [3:0] signal_out;
  logic       moving;
  logic       step_tick;

  modport master (output direction, en, input signal_out, moving, step_tick);
  modport slave  (input direction, en, output signal_out, moving, step_tick);
endinterface

// File: rtl/step_rate_gen.sv
// step_rate_gen: trapezoidal step-rate generator.
// Ports:
//   clk, rst     : clock, async active-high reset
//   i_en         : enable; low forces IDLE with the start period
//   i_dir        : direction command
//   o_step       : combinational, high on the edge that takes a step
//   o_fwd        : latched direction of the current move is forward
//   o_moving     : state is not IDLE
//   o_step_tick  : registered step pulse (cycle after the step edge)
module step_rate_gen
  import stepper_pkg::*;
#(
  parameter logic [31:0] P_START = 32'd1000000,
  parameter logic [31:0] P_MIN   = 32'd100000,
  parameter logic [31:0] P_DEC   = 32'd56250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_dir,
  output logic       o_step,
  output logic       o_fwd,
  output logic       o_moving,
  output logic       o_step_tick
);

  state_e      r_state;
  logic [31:0] r_period;
  logic [31:0] r_cnt;
  logic [1:0]  r_cur_dir;
  logic        r_tick;

  logic        w_same;
  logic        w_go;
  logic [31:0] w_acc_p;
  logic [31:0] w_dec_p;

  assign w_same  = (i_dir == r_cur_dir);
  assign w_go    = (i_dir == DIR_FWD) || (i_dir == DIR_REV);
  assign o_step  = i_en && (r_state != IDLE) && (r_cnt == r_period - 32'd1);
  // Saturating ramp arithmetic, written to avoid unsigned wrap.
  assign w_acc_p = (r_period >= P_MIN + P_DEC) ? r_period - P_DEC : P_MIN;
  assign w_dec_p = (r_period + P_DEC <= P_START) ? r_period + P_DEC : P_START;

  assign o_fwd       = (r_cur_dir == DIR_FWD);
  assign o_moving    = (r_state != IDLE);
  assign o_step_tick = r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_period  <= P_START;
      r_cnt     <= '0;
      r_cur_dir <= DIR_FWD;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= o_step;
      if (!i_en) begin
        r_state  <= IDLE;
        r_period <= P_START;
        r_cnt    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_period <= P_START;
            r_cnt    <= '0;
            if (w_go) begin
              r_cur_dir <= i_dir;
              r_state   <= ACCEL;
            end
          end
          ACCEL: begin
            r_cnt <= o_step ? 32'd0 : r_cnt + 32'd1;
            if (o_step) r_period <= w_acc_p;
            if (!w_same)                         r_state <= DECEL;
            else if (o_step && w_acc_p == P_MIN) r_state <= CRUISE;
          end
          CRUISE: begin
            r_cnt <= o_step ? 32'd0 : r_cnt + 32'd1;
            if (!w_same) r_state <= DECEL;
          end
          DECEL: begin
            r_cnt <= o_step ? 32'd0 : r_cnt + 32'd1;
            // The step at the start rate is the last one of the move.
            if (o_step && r_period == P_START) begin
              r_state <= IDLE;
            end else begin
              if (o_step) r_period <= w_dec_p;
              if (w_same) r_state <= ACCEL;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/stepper_ramp_driver.sv
// stepper_ramp_driver: one Pmod STEP axis with trapezoidal speed ramp.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : stepper_ramp_driver_if.slave (direction, en in;
//              signal_out, moving, step_tick out)
// Build option: STEPPER_HALF_STEP_EN selects the 8-phase half-step table,
// otherwise the 4-phase full-step table is used.
module stepper_ramp_driver
  import stepper_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned MIN_RATE_HZ = 100,
  parameter int unsigned MAX_RATE_HZ = 1000,
  parameter int unsigned RAMP_STEPS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  stepper_ramp_driver_if.slave  bus
);

  localparam logic [31:0] P_START   = 32'(CLK_HZ / MIN_RATE_HZ);
  localparam logic [31:0] P_MIN     = 32'(CLK_HZ / MAX_RATE_HZ);
  localparam logic [31:0] P_DEC_RAW = (P_START - P_MIN) / 32'(RAMP_STEPS);
  localparam logic [31:0] P_DEC     = (P_DEC_RAW == 32'd0) ? 32'd1 : P_DEC_RAW;

`ifdef STEPPER_HALF_STEP_EN
  localparam int PH_W = 3;
  function automatic logic [3:0] pat(input logic [PH_W-1:0] ph);
    return HALF_PAT[ph];
  endfunction
`else
  localparam int PH_W = 2;
  function automatic logic [3:0] pat(input logic [PH_W-1:0] ph);
    return FULL_PAT[ph];
  endfunction
`endif

  logic            w_step;
  logic            w_fwd;
  logic            w_moving;
  logic            w_tick;
  logic [PH_W-1:0] r_phase;
  logic [PH_W-1:0] w_phase_nxt;
  logic [3:0]      r_sig;

  step_rate_gen #(
    .P_START(P_START),
    .P_MIN  (P_MIN),
    .P_DEC  (P_DEC)
  ) u_rate (
    .clk        (clk),
    .rst        (rst),
    .i_en       (bus.en),
    .i_dir      (bus.direction),
    .o_step     (w_step),
    .o_fwd      (w_fwd),
    .o_moving   (w_moving),
    .o_step_tick(w_tick)
  );

  // Phase wraps naturally at the table length (power of two).
  assign w_phase_nxt = !w_step ? r_phase :
                       w_fwd   ? r_phase + 1'b1 : r_phase - 1'b1;

  // The pattern register looks at the next phase so the new pattern
  // appears in the same cycle as step_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_sig   <= 4'b0000;
    end else begin
      r_phase <= w_phase_nxt;
      r_sig   <= bus.en ? pat(w_phase_nxt) : 4'b0000;
    end
  end

  assign bus.signal_out = r_sig;
  assign bus.moving     = w_moving;
  assign bus.step_tick  = w_tick;

endmodule

// File: tb/tb_stepper_ramp_driver.sv
module tb_stepper_ramp_driver;
  localparam int PS = 10;
  localparam int PM = 2;
  localparam int PD = 2;
`ifdef STEPPER_HALF_STEP_EN
  localparam int NPH = 8;
  localparam logic [3:0] IDLE_PAT  = 4'b1000;
  localparam logic [3:0] FIRST_FWD = 4'b1100;
`else
  localparam int NPH = 4;
  localparam logic [3:0] IDLE_PAT  = 4'b1100;
  localparam logic [3:0] FIRST_FWD = 4'b0110;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  stepper_ramp_driver_if bus();

  stepper_ramp_driver #(
    .CLK_HZ(1000), .MIN_RATE_HZ(100), .MAX_RATE_HZ(500), .RAMP_STEPS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [3:0] pat [8];
  int  total = 0;
  int  bad   = 0;
  bit  chk_on = 1'b0;

  // Behavioural model: mode 0 idle, 1 speeding up, 2 cruising, 3 slowing.
  // Steps are scheduled by absolute edge number (m_due).
  int         m_mode  = 0;
  int         m_int   = PS;
  int         m_due   = 0;
  int         m_phase = 0;
  int         m_cyc   = 0;
  logic [1:0] m_dir   = 2'b01;
  logic [3:0] e_sig   = 4'b0;
  logic       e_mov   = 1'b0;
  logic       e_tick  = 1'b0;

  int         steps[$];
  logic [3:0] spat[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic model_edge();
    logic [1:0] d;
    bit same, stp, done;
    d = bus.direction;
    m_cyc++;
    e_tick = 1'b0;
    if (!bus.en) begin
      m_mode = 0;
      m_int  = PS;
    end else if (m_mode == 0) begin
      if (d == 2'b01 || d == 2'b10) begin
        m_dir  = d;
        m_mode = 1;
        m_int  = PS;
        m_due  = m_cyc + PS;
      end
    end else begin
      same = (d == m_dir);
      stp  = (m_cyc == m_due);
      done = 1'b0;
      if (stp) begin
        e_tick  = 1'b1;
        m_phase = (m_dir == 2'b01) ? (m_phase + 1) % NPH : (m_phase + NPH - 1) % NPH;
        if (m_mode == 1) m_int = (m_int - PD < PM) ? PM : m_int - PD;
        else if (m_mode == 3) begin
          if (m_int == PS) done = 1'b1;
          else m_int = (m_int + PD > PS) ? PS : m_int + PD;
        end
        m_due = m_cyc + m_int;
      end
      if (done) m_mode = 0;
      else begin
        case (m_mode)
          1: if (!same) m_mode = 3; else if (stp && m_int == PM) m_mode = 2;
          2: if (!same) m_mode = 3;
          3: if (same) m_mode = 1;
          default: ;
        endcase
      end
    end
    e_sig = bus.en ? pat[m_phase] : 4'b0000;
    e_mov = (m_mode != 0);
  endtask

  initial begin
`ifdef STEPPER_HALF_STEP_EN
    pat = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
    pat = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
  end

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_int = PS; m_phase = 0;
      e_sig = 4'b0; e_mov = 1'b0; e_tick = 1'b0;
    end else begin
      model_edge();
    end
  end

  // Per-cycle compare plus step log (edge number and pattern).
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("cyc_signal_out", bus.signal_out, e_sig);
      chk("cyc_moving", bus.moving, e_mov);
      chk("cyc_step_tick", bus.step_tick, e_tick);
    end
    if (bus.step_tick) begin
      steps.push_back(m_cyc);
      spat.push_back(bus.signal_out);
    end
  end

  task automatic wait_steps(input int n, input int budget);
    int k = 0;
    while (steps.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    if (steps.size() < n) begin
      total++; bad++;
      $display("FAIL wait_steps: got %0d steps expected %0d", steps.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.moving !== 1'b0 && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk("wait_idle", bus.moving, 0);
  endtask

  task automatic chk_ints(input string nm, input int ref0, input int ex[$]);
    int prev = ref0;
    foreach (ex[i]) begin
      if (i < steps.size()) begin
        chk($sformatf("%s_int%0d", nm, i), steps[i] - prev, ex[i]);
        prev = steps[i];
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0, prev;
    logic [3:0] lastp;
    logic [3:0] ep[$];
`ifdef STEPPER_HALF_STEP_EN
    ep = '{4'b1100, 4'b0100, 4'b0110, 4'b0010};
`else
    ep = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
`endif
    bus.en = 1'b1;
    bus.direction = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("rst_sig", bus.signal_out, 0);
    chk("rst_moving", bus.moving, 0);
    chk("rst_tick", bus.step_tick, 0);
    #19 rst = 1'b0;
    chk_on = 1'b1;

    // idle hold
    repeat (100) @(negedge clk);
    #1;
    chk("idle_steps", steps.size(), 0);
    chk("idle_pat", bus.signal_out, IDLE_PAT);
    chk("idle_moving", bus.moving, 0);

    // forward accel into cruise
    t0 = m_cyc + 1;
    bus.direction = 2'b01;
    wait_steps(8, 300);
    chk_ints("fwd", t0, '{10, 8, 6, 4, 2, 2, 2, 2});
    foreach (ep[i]) chk($sformatf("fwd_pat%0d", i), spat[i], ep[i]);

    // stop from cruise
    prev = steps[$];
    steps.delete(); spat.delete();
    bus.direction = 2'b00;
    wait_idle(200);
    chk("stop_cnt", steps.size(), 5);
    chk_ints("stop", prev, '{2, 4, 6, 8, 10});

    // reversal from cruise
    repeat (3) @(negedge clk);
    #1;
    steps.delete(); spat.delete();
    bus.direction = 2'b01;
    wait_steps(6, 300);
    prev = steps[$];
    steps.delete(); spat.delete();
    bus.direction = 2'b10;
    wait_steps(8, 300);
    chk_ints("rev", prev, '{2, 4, 6, 8, 10, 11, 8, 6});
    chk("rev_phase_back", spat[5], spat[3]);

    // enable drop mid-accel
    lastp = spat[$];
    bus.en = 1'b0;
    @(negedge clk); #1;
    chk("en_off_sig", bus.signal_out, 0);
    chk("en_off_moving", bus.moving, 0);
    repeat (4) @(negedge clk);
    #1;
    steps.delete(); spat.delete();
    t0 = m_cyc + 1;
    bus.en = 1'b1;
    @(negedge clk); #1;
    chk("en_on_pat", bus.signal_out, lastp);
    wait_steps(1, 50);
    chk("en_on_int", steps[0] - t0, 10);

    // reset mid-cruise
    bus.direction = 2'b01;
    repeat (300) @(negedge clk);
    #1;
    chk("pre_rst_moving", bus.moving, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst2_sig", bus.signal_out, 0);
    chk("rst2_moving", bus.moving, 0);
    chk("rst2_tick", bus.step_tick, 0);
    steps.delete(); spat.delete();
    @(negedge clk); #1;
    t0 = m_cyc + 1;
    rst = 1'b0;
    wait_steps(1, 50);
    chk("rst_first_pat", spat[0], FIRST_FWD);
    chk("rst_first_int", steps[0] - t0, 10);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stepper_ramp_driver.md
# stepper_ramp_driver

- Consumes the 2-bit direction code from `jstk_data_decoder` and drives the four coil lines of one Pmod STEP header.
- Replaces a fixed-rate step output with a trapezoidal speed profile: accelerate from a start rate to a cruise rate, then decelerate before stopping or reversing.
- One instance per axis (X, Y) in the joystick stepper top level; the per-axis enable switch is wired to `en`.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `MIN_RATE_HZ`, 100, start/stop step rate (steps/s).
- `MAX_RATE_HZ`, 1000, cruise step rate (steps/s).
- `RAMP_STEPS`, 16, steps to ramp from start to cruise rate.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `direction`  in  2  01 = forward, 10 = reverse, 00/11 = stop.
- `en`  in  1  axis enable; 0 de-energizes coils.
- `signal_out`  out  4  coil drive pattern to Pmod STEP.
- `moving`  out  1  1 when state is not IDLE.
- `step_tick`  out  1  one-cycle pulse on every step.

## Operation
- Derived localparams:
  - P_START = CLK_HZ/MIN_RATE_HZ
  - P_MIN = CLK_HZ/MAX_RATE_HZ
  - P_DEC = (P_START-P_MIN)/RAMP_STEPS, forced to at least 1.
- Period register is 32 bits. Counter `cnt` runs 0..period-1. A step occurs on the edge where `cnt == period-1`; `cnt` then returns to 0.
- States:
  - IDLE:
    - period = P_START, cnt held at 0.
    - Forward/reverse command latches `cur_dir` and moves to ACCEL.
  - ACCEL:
    - Each step sets period = max(period-P_DEC, P_MIN).
    - Goes to CRUISE when the new period equals P_MIN.
  - CRUISE:
    - Period is held.
  - DECEL:
    - Each step first checks period. If period == P_START, the step is taken and the state goes to IDLE.
    - Otherwise period = min(period+P_DEC, P_START).
- Transitions out of ACCEL/CRUISE:
  - Stop command, or command opposite to `cur_dir`, goes to DECEL.
- Transitions out of DECEL:
  - Command equal to `cur_dir` goes back to ACCEL; period continues from its current value.
- Reversal: the block decelerates fully to IDLE. A still-opposite command then restarts ACCEL in the new direction on the following cycle.
- Phase index: forward increments it, reverse decrements it, modulo the sequence length. It is retained through IDLE and through `en` = 0.
- Full-step sequence for phases 0..3: 1100, 0110, 0011, 1001.
- `signal_out` is registered: `en` ? pattern[phase] : 0000. In IDLE with `en` = 1, the coils hold the last pattern (holding torque).
- `en` falling in any state: next edge forces IDLE, period = P_START, cnt = 0. The phase is kept.
- Reset values:
  - `signal_out` = 0000, `moving` = 0, `step_tick` = 0.
  - Phase 0, state IDLE, period = P_START, cnt = 0.

## Timing
- `direction` is treated as synchronous to `clk`; the decoder output is already registered upstream.
- A command sampled on edge k moves IDLE to ACCEL on edge k. The first step happens P_START edges later.
- On a step edge:
  - The phase advances.
  - `step_tick` is high for the cycle after that edge.
  - `signal_out` shows the new pattern in that same cycle.
- A command change is acted on at the next edge. The step interval already in progress always completes; there is no truncation.
- `moving` is high from the first ACCEL cycle until the cycle after the final DECEL step.

## Configuration
- `STEPPER_HALF_STEP_EN` defined: 8-phase half-step sequence 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001, with phase index 0..7.
- Undefined: 4-phase full-step sequence as above, with phase index 0..3.
- The ramp arithmetic is identical in both modes.

## Structure
- Package `stepper_pkg` holds:
  - The direction codes (DIR_STOP, DIR_FWD, DIR_REV).
  - The state enum (IDLE, ACCEL, CRUISE, DECEL).
  - Both phase-pattern tables.
- Sub-module `step_rate_gen`: period register, cnt, ramp state machine and `step_tick`.
- The top of the block holds the phase index, pattern lookup and `en` gating.

## Test plan
Bench parameters: CLK_HZ=1000, MIN_RATE_HZ=100, MAX_RATE_HZ=500, RAMP_STEPS=4, giving P_START=10, P_MIN=2, P_DEC=2.
- Reset, `en`=1, direction=00 → `signal_out` = 1100 (phase 0 holding), `moving`=0, no `step_tick` over 100 cycles.
- Direction=01 held → step intervals 10, 8, 6, 4, 2, 2, 2…; `signal_out` cycles 0110, 0011, 1001, 1100.
- In CRUISE, direction to 00 → further intervals 2, 4, 6, 8, 10 (5 steps), then IDLE, `moving`=0, pattern held.
- In CRUISE, direction to 10 → full decel as above, IDLE for one cycle, then reverse ACCEL with intervals 10, 8…; phase decrements.
- `en`=0 mid-ACCEL → next cycle `signal_out`=0000, `moving`=0. `en`=1 restores the pattern of the last phase, and the first interval is 10.
- `rst` pulsed mid-CRUISE → outputs 0000/0/0 asynchronously. With `STEPPER_HALF_STEP_EN`, a forward run gives 1100, 0100, 0110… from phase 0.
